instr_fetch: RTL and testbench

//  Instruction fetch unit: the producer side of the IW interface that feeds CarDecoder.

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/instr_fetch_iw_length_decode.sv | 43 ++++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit and its length decoder.
// Holds the fetch FSM state type, the opcode/format masks, the addressing-mode
// codes and the register numbers used by the extension-word rules.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    ST_VECTOR,
    ST_FETCH_IW,
    ST_FETCH_SRC,
    ST_FETCH_DST,
    ST_HOLD
  } if_state_t;

  // Format II opcode prefix IW[15:10] and jump prefix IW[15:13]
  localparam logic [5:0] FMT2_OPC = 6'b000100;
  localparam logic [2:0] JMP_OPC  = 3'b001;
  // Format I opcodes start at IW[15:12] == 4
  localparam logic [3:0] FMT1_MIN = 4'd4;

  // Source addressing modes that can pull an extension word
  localparam logic [1:0] IDX_MODE = 2'b01;
  localparam logic [1:0] INC_MODE = 2'b11;

  // R0 is the PC (immediate via @PC+), R3 is the constant generator
  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R3 = 4'd3;

  function automatic logic [15:0] word_align(input logic [15:0] a);
    return a & 16'hFFFE;
  endfunction

endpackage

// File: rtl/instr_fetch_iw_length_decode.sv
// iw_length_decode: combinational instruction-length decoder.
// Ports:
//   iw       in  16  instruction word
//   src_ext  out 1   a source extension word follows the IW
//   dst_ext  out 1   a destination extension word follows (format I only)
//   illegal  out 1   IW matches no format I / format II / jump encoding
module iw_length_decode
  import instr_fetch_pkg::*;
(
  input  logic [15:0] iw,
  output logic        src_ext,
  output logic        dst_ext,
  output logic        illegal
);

  logic       fmt1;
  logic       fmt2;
  logic       jmp;
  logic [1:0] as_mode;
  logic [3:0] rs;
  logic       src_needs_word;
  logic       unused_bw;

  // Byte/word flag does not affect instruction length
  assign unused_bw = iw[6];

  always_comb begin
    fmt1    = (iw[15:12] >= FMT1_MIN);
    fmt2    = (iw[15:10] == FMT2_OPC);
    jmp     = (iw[15:13] == JMP_OPC);
    as_mode = iw[5:4];
    rs      = fmt1 ? iw[11:8] : iw[3:0];

    // R3 never takes a word; R2 only in absolute mode (As=01); R0 with As=11 is #imm
    src_needs_word = ((as_mode == IDX_MODE) && (rs != R3)) ||
                     ((as_mode == INC_MODE) && (rs == R0));

    src_ext = (fmt1 || fmt2) && src_needs_word;
    dst_ext = fmt1 && iw[7];
    illegal = !(fmt1 || fmt2 || jmp);
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit feeding the decoder over a valid/ready link.
// Loads PC from the reset vector, reads the IW and 0-2 extension words, then
// holds {IW, SRC_EXT, DST_EXT, IW_PC, ILLEGAL} until the consumer accepts it.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   MEM_REQ/ADDR/ACK/RDATA program-memory read port (request held until ACK)
//   PC_LOAD, PC_NEW       single-cycle redirect and its target (bit0 ignored)
//   IFU_VALID, IFU_READY  output bundle handshake
//   IW, SRC_EXT, DST_EXT, IW_PC, ILLEGAL  output bundle
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_RDATA,
  input  logic        PC_LOAD,
  input  logic [15:0] PC_NEW,
  output logic        IFU_VALID,
  input  logic        IFU_READY,
  output logic [15:0] IW,
  output logic [15:0] SRC_EXT,
  output logic [15:0] DST_EXT,
  output logic [15:0] IW_PC,
  output logic        ILLEGAL
);

  if_state_t   state, state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        need_dst;
  logic        valid_q;
  logic        ack;
  logic        redirect;
  logic        dec_src, dec_dst, dec_ill;

  // Decode acts on the word being latched into IW
  iw_length_decode u_len (
    .iw      (MEM_RDATA),
    .src_ext (dec_src),
    .dst_ext (dec_dst),
    .illegal (dec_ill)
  );

  assign pc_inc    = pc + 16'd2;
  assign IFU_VALID = valid_q;

  always_comb begin
    // Reset drops the request immediately rather than a cycle later
    MEM_REQ  = rst_n && (state != ST_HOLD);
    MEM_ADDR = '0;
    if (MEM_REQ) begin
      MEM_ADDR = (state == ST_VECTOR) ? word_align(RESET_VEC) : pc;
    end
    ack      = MEM_REQ && MEM_ACK;
    redirect = PC_LOAD && (state != ST_VECTOR);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_VECTOR:    if (ack) state_nxt = ST_FETCH_IW;
      ST_FETCH_IW:  if (ack) state_nxt = dec_src ? ST_FETCH_SRC :
                                         dec_dst ? ST_FETCH_DST : ST_HOLD;
      ST_FETCH_SRC: if (ack) state_nxt = need_dst ? ST_FETCH_DST : ST_HOLD;
      ST_FETCH_DST: if (ack) state_nxt = ST_HOLD;
      ST_HOLD:      if (IFU_READY) state_nxt = ST_FETCH_IW;
      default:      state_nxt = ST_VECTOR;
    endcase
    if (redirect) state_nxt = ST_FETCH_IW;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_VECTOR;
      pc       <= '0;
      need_dst <= 1'b0;
      valid_q  <= 1'b0;
      IW       <= '0;
      SRC_EXT  <= '0;
      DST_EXT  <= '0;
      IW_PC    <= '0;
      ILLEGAL  <= 1'b0;
    end else begin
      state   <= state_nxt;
      // VALID is a register that mirrors entry into HOLD
      valid_q <= (state_nxt == ST_HOLD);
      if (redirect) begin
        // Redirect beats any coincident ACK; partial fetch is abandoned
        pc <= word_align(PC_NEW);
      end else if (ack) begin
        unique case (state)
          ST_VECTOR: pc <= word_align(MEM_RDATA);
          ST_FETCH_IW: begin
            IW       <= MEM_RDATA;
            IW_PC    <= pc;
            pc       <= pc_inc;
            SRC_EXT  <= '0;
            DST_EXT  <= '0;
            ILLEGAL  <= dec_ill;
            need_dst <= dec_dst;
          end
          ST_FETCH_SRC: begin
            SRC_EXT <= MEM_RDATA;
            pc      <= pc_inc;
          end
          ST_FETCH_DST: begin
            DST_EXT <= MEM_RDATA;
            pc      <= pc_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a zero-wait memory responder checks fetch
// addresses in order, a bundle monitor checks each accepted output bundle.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic        PC_LOAD;
  logic [15:0] PC_NEW;
  logic        IFU_VALID;
  logic        IFU_READY;
  logic [15:0] IW, SRC_EXT, DST_EXT, IW_PC;
  logic        ILLEGAL;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_VEC(16'hFFFE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_ACK   (MEM_ACK),
    .MEM_RDATA (MEM_RDATA),
    .PC_LOAD   (PC_LOAD),
    .PC_NEW    (PC_NEW),
    .IFU_VALID (IFU_VALID),
    .IFU_READY (IFU_READY),
    .IW        (IW),
    .SRC_EXT   (SRC_EXT),
    .DST_EXT   (DST_EXT),
    .IW_PC     (IW_PC),
    .ILLEGAL   (ILLEGAL)
  );

  typedef struct packed {
    logic [15:0] iw;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] pc;
    logic        ill;
  } bundle_t;

  bundle_t     exp_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] mem [0:32767];
  logic        ack_en;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_addr(input logic [15:0] a, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (MEM_REQ && MEM_ADDR == a) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_addr actual=timeout required=%0h", a);
  endtask

  // Zero-wait memory; every acknowledged read is checked against the expected address order
  initial begin
    logic [15:0] e;
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge clk);
      MEM_ACK   = MEM_REQ && ack_en;
      MEM_RDATA = MEM_REQ ? mem[MEM_ADDR[15:1]] : 16'h0000;
      if (MEM_ACK) begin
        if (addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_fetch actual=%0h required=none", MEM_ADDR);
        end else begin
          e = addr_q.pop_front();
          chk("fetch_addr", MEM_ADDR, e);
        end
      end
    end
  end

  // Bundle monitor
  initial begin
    bundle_t e;
    forever begin
      @(negedge clk);
      if (IFU_VALID && IFU_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bundle actual=%0h required=none", IW);
        end else begin
          e = exp_q.pop_front();
          chk("bundle", {IW, SRC_EXT, DST_EXT, IW_PC, ILLEGAL}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'hFFFE >> 1] = 16'h4400;
    mem[16'h4400 >> 1] = 16'h4506;  // MOV R5,R6
    mem[16'h4402 >> 1] = 16'h40B6;  // MOV #0x1234,4(R6)
    mem[16'h4404 >> 1] = 16'h1234;
    mem[16'h4406 >> 1] = 16'h0004;
    mem[16'h4408 >> 1] = 16'h5315;  // ADD #1,R5 (CG)
    mem[16'h440A >> 1] = 16'h4215;  // MOV &0x0200,R5
    mem[16'h440C >> 1] = 16'h0200;
    mem[16'h440E >> 1] = 16'h3C00;  // JMP
    mem[16'h4410 >> 1] = 16'h0000;  // illegal
    mem[16'h4412 >> 1] = 16'h1005;  // format II, register mode
    mem[16'h4414 >> 1] = 16'h40B6;
    mem[16'h4416 >> 1] = 16'h1111;
    mem[16'h5000 >> 1] = 16'h4506;
    mem[16'h5002 >> 1] = 16'h40B6;
    mem[16'h5004 >> 1] = 16'h2222;
    mem[16'h5006 >> 1] = 16'h3333;

    addr_q = '{16'hFFFE, 16'h4400, 16'h4402, 16'h4404, 16'h4406, 16'h4408,
               16'h440A, 16'h440C, 16'h440E, 16'h4410, 16'h4412, 16'h4414,
               16'h4416, 16'h5000, 16'h5002, 16'h5004, 16'hFFFE, 16'h4400};

    exp_q.push_back('{16'h4506, 16'h0000, 16'h0000, 16'h4400, 1'b0});
    exp_q.push_back('{16'h40B6, 16'h1234, 16'h0004, 16'h4402, 1'b0});
    exp_q.push_back('{16'h5315, 16'h0000, 16'h0000, 16'h4408, 1'b0});
    exp_q.push_back('{16'h4215, 16'h0200, 16'h0000, 16'h440A, 1'b0});
    exp_q.push_back('{16'h3C00, 16'h0000, 16'h0000, 16'h440E, 1'b0});
    exp_q.push_back('{16'h0000, 16'h0000, 16'h0000, 16'h4410, 1'b1});
    exp_q.push_back('{16'h1005, 16'h0000, 16'h0000, 16'h4412, 1'b0});
    exp_q.push_back('{16'h4506, 16'h0000, 16'h0000, 16'h5000, 1'b0});
    exp_q.push_back('{16'h4506, 16'h0000, 16'h0000, 16'h4400, 1'b0});

    rst_n     = 1'b0;
    PC_LOAD   = 1'b0;
    PC_NEW    = 16'h0000;
    IFU_READY = 1'b1;
    ack_en    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {MEM_REQ, MEM_ADDR, IFU_VALID, ILLEGAL}, '0);
    chk("rst_bundle", {IW, SRC_EXT, DST_EXT, IW_PC}, '0);

    rst_n = 1'b1;
    #1;
    chk("vector_req", {MEM_REQ, MEM_ADDR, IFU_VALID}, {1'b1, 16'hFFFE, 1'b0});
    @(posedge clk); #1;
    chk("first_fetch", {MEM_REQ, MEM_ADDR, IFU_VALID}, {1'b1, 16'h4400, 1'b0});
    @(posedge clk); #1;
    chk("one_word_hold", {IFU_VALID, MEM_REQ}, {1'b1, 1'b0});
    @(posedge clk); #1;
    chk("two_cycle_issue", {MEM_REQ, MEM_ADDR}, {1'b1, 16'h4402});

    // Stall the consumer on the format II instruction
    wait_addr(16'h4412, 40);
    IFU_READY = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold_stable", {IFU_VALID, MEM_REQ, IW, IW_PC, SRC_EXT, DST_EXT, ILLEGAL},
          {1'b1, 1'b0, 16'h1005, 16'h4412, 16'h0000, 16'h0000, 1'b0});
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    IFU_READY = 1'b1;
    @(posedge clk); #1;
    chk("release_fetch", {MEM_REQ, MEM_ADDR, IFU_VALID}, {1'b1, 16'h4414, 1'b0});

    // Redirect during FETCH_SRC, coincident with an ACK
    wait_addr(16'h4416, 10);
    PC_LOAD = 1'b1;
    PC_NEW  = 16'h5001;
    @(posedge clk); #1;
    PC_LOAD = 1'b0;
    chk("redirect", {MEM_REQ, MEM_ADDR, IFU_VALID}, {1'b1, 16'h5000, 1'b0});

    // Reset in FETCH_DST
    wait_addr(16'h5006, 20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ctl", {MEM_REQ, MEM_ADDR, IFU_VALID, ILLEGAL}, '0);
    chk("midrst_bundle", {IW, SRC_EXT, DST_EXT, IW_PC}, '0);
    IFU_READY = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (!IFU_VALID && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_latency", n, 2);
    IFU_READY = 1'b1;
    @(posedge clk); #1;
    IFU_READY = 1'b0;
    ack_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bundles_drained", exp_q.size(), 0);
    chk("fetches_drained", addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
